// File: rtl/bch_chien_search_ctrl.sv
// bch_chien_search_ctrl
//
// Chien search sequencer for the GF(2^13) BCH decoder.
// It loads T+1 pre-scaled error-locator coefficients into a register ribbon.
// Once per position it steps each ribbon entry r_j by alpha^j and XORs the ribbon.
// Each position where the sum is zero is reported as an error location.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   coef_valid  coefficient beat valid
//   coef_ready  block accepts a coefficient (IDLE/LOAD only)
//   coef_data   lambda_j, beats in order j = 0..T
//   deg         degree of Lambda, sampled with beat j = 0
//   err_valid   error position valid
//   err_ready   downstream accepts the error position
//   err_pos     position index i with Lambda(step i) == 0
//   done        one-cycle pulse when the search of a codeword ends
//   err_cnt     number of zeros found (saturates at 63), held until next load
//   fail        err_cnt != deg_latched or deg_latched > T, held like err_cnt
//
// Build option:
//   CHIEN_EARLY_EXIT_EN  when defined, the search stops right after the
//                        error handshake that brings err_cnt up to the latched
//                        degree (or up to T). The remaining positions are skipped.

module bch_chien_search_ctrl #(
    parameter int          T    = 32,
    parameter int          N    = 8191,
    parameter logic [12:0] POLY = 13'h001B
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        coef_valid,
    output logic        coef_ready,
    input  logic [12:0] coef_data,
    input  logic [5:0]  deg,
    output logic        err_valid,
    input  logic        err_ready,
    output logic [12:0] err_pos,
    output logic        done,
    output logic [5:0]  err_cnt,
    output logic        fail
);

    localparam int BW = $clog2(T + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SEARCH, HOLD, DONE} state_t;

    state_t       state;
    logic [12:0]  ribbon      [0:T];
    logic [12:0]  ribbon_next [0:T];
    logic [12:0]  sum;
    logic [BW-1:0] beat_idx;
    logic [12:0]  pos;
    logic [5:0]   deg_latched;
    logic         last_hit;
    logic [5:0]   err_cnt_inc;
    logic         fail_now;
    logic         early_exit;

    // Multiply by alpha: shift left, then fold x^13 back in through the primitive polynomial.
    function automatic logic [12:0] mul_alpha(input logic [12:0] x);
        return {x[11:0], 1'b0} ^ (x[12] ? POLY : 13'd0);
    endfunction

    // j-fold alpha multiply. The loop bound is constant, so this unrolls into a fixed chain.
    function automatic logic [12:0] mul_alpha_pow(input logic [12:0] x, input int j);
        logic [12:0] v;
        v = x;
        for (int k = 0; k < T; k++) begin
            if (k < j) v = mul_alpha(v);
        end
        return v;
    endfunction

    // Next ribbon contents and the XOR sum that evaluates Lambda at the current position.
    always_comb begin
        sum = '0;
        for (int j = 0; j <= T; j++) begin
            ribbon_next[j] = mul_alpha_pow(ribbon[j], j);
            sum            = sum ^ ribbon[j];
        end
    end

    assign err_cnt_inc = (err_cnt == 6'd63) ? err_cnt : err_cnt + 6'd1;
    assign fail_now    = (err_cnt != deg_latched) || (int'(deg_latched) > T);

`ifdef CHIEN_EARLY_EXIT_EN
    // err_cnt already counts the zero being handed off while in HOLD.
    assign early_exit = (err_cnt == deg_latched) || (int'(err_cnt) == T);
`else
    assign early_exit = 1'b0;
`endif

    // Control FSM. It also owns the ribbon and all registered outputs.
    // done is a default-low pulse. It is set only on entry into DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            coef_ready  <= 1'b0;
            err_valid   <= 1'b0;
            err_pos     <= '0;
            done        <= 1'b0;
            err_cnt     <= '0;
            fail        <= 1'b0;
            beat_idx    <= '0;
            pos         <= '0;
            deg_latched <= '0;
            last_hit    <= 1'b0;
            for (int j = 0; j <= T; j++) ribbon[j] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    coef_ready <= 1'b1;
                    if (coef_valid && coef_ready) begin
                        ribbon[0]   <= coef_data;
                        deg_latched <= deg;
                        err_cnt     <= '0;
                        fail        <= 1'b0;
                        beat_idx    <= BW'(1);
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    if (coef_valid && coef_ready) begin
                        ribbon[beat_idx] <= coef_data;
                        beat_idx         <= beat_idx + BW'(1);
                        if (beat_idx == BW'(T)) begin
                            coef_ready <= 1'b0;
                            pos        <= '0;
                            last_hit   <= 1'b0;
                            state      <= SEARCH;
                        end
                    end
                end
                SEARCH: begin
                    // The ribbon and the position advance on every step, including a zero step.
                    for (int j = 0; j <= T; j++) ribbon[j] <= ribbon_next[j];
                    pos <= pos + 13'd1;
                    if (sum == 13'd0) begin
                        err_pos   <= pos;
                        err_valid <= 1'b1;
                        err_cnt   <= err_cnt_inc;
                        last_hit  <= (pos == 13'(N - 1));
                        state     <= HOLD;
                    end else if (pos == 13'(N - 1)) begin
                        done  <= 1'b1;
                        fail  <= fail_now;
                        state <= DONE;
                    end
                end
                HOLD: begin
                    if (err_ready) begin
                        err_valid <= 1'b0;
                        if (last_hit || early_exit) begin
                            done  <= 1'b1;
                            fail  <= fail_now;
                            state <= DONE;
                        end else begin
                            state <= SEARCH;
                        end
                    end
                end
                DONE: begin
                    coef_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bch_chien_search_ctrl.sv
// tb_bch_chien_search_ctrl
//
// Directed bench for bch_chien_search_ctrl. It loads hand-built locator polynomials with
// known roots and checks the reported error positions, the timing, err_cnt and fail.
// Inputs are driven on the falling edge. Outputs are sampled on the falling edge.

module tb_bch_chien_search_ctrl;

    localparam int          T     = 32;
    localparam int          N     = 8191;
    localparam logic [12:0] POLY  = 13'h001B;
    localparam int          LIMIT = N + 200;

    logic        clk;
    logic        rst_n;
    logic        coef_valid;
    logic        coef_ready;
    logic [12:0] coef_data;
    logic [5:0]  deg;
    logic        err_valid;
    logic        err_ready;
    logic [12:0] err_pos;
    logic        done;
    logic [5:0]  err_cnt;
    logic        fail;

    int          checks;
    int          errors;
    int          err_q[$];
    logic [12:0] coefs [0:T];

    bch_chien_search_ctrl #(.T(T), .N(N), .POLY(POLY)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_data  (coef_data),
        .deg        (deg),
        .err_valid  (err_valid),
        .err_ready  (err_ready),
        .err_pos    (err_pos),
        .done       (done),
        .err_cnt    (err_cnt),
        .fail       (fail)
    );

    // 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted error position in order.
    always @(posedge clk) begin
        if (rst_n && err_valid && err_ready) err_q.push_back(int'(err_pos));
    end

    // Safety stop in case a wait somewhere is not bounded the way it should be.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Divide by alpha. This is the inverse of the shift-and-fold alpha multiply.
    function automatic logic [12:0] div_alpha(input logic [12:0] x);
        logic [13:0] y;
        y = {1'b0, x};
        if (x[0]) y = y ^ {1'b1, POLY};
        return y[13:1];
    endfunction

    function automatic logic [12:0] alpha_neg(input int k);
        logic [12:0] v;
        v = 13'd1;
        for (int i = 0; i < k; i++) v = div_alpha(v);
        return v;
    endfunction

    task automatic set_coefs(input logic [12:0] l0, input logic [12:0] l1, input logic [12:0] l2);
        for (int j = 0; j <= T; j++) coefs[j] = 13'd0;
        coefs[0] = l0;
        coefs[1] = l1;
        coefs[2] = l2;
    endtask

    // Stream coefs[0..T] into the block. The task returns at the falling edge just after
    // beat T was accepted, which is the first cycle after beat T.
    task automatic applyStimulus(input logic [5:0] d, input bit junk);
        int guard;
        for (int j = 0; j <= T; j++) begin
            coef_valid = 1'b1;
            coef_data  = coefs[j];
            deg        = d;
            guard      = 0;
            while (!coef_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) checkOutput("load_ready_timeout", 32'd0, 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        if (!junk) coef_valid = 1'b0;
    endtask

    // Run until done with err_ready high. Cycles are counted from 1 at the first cycle after beat T.
    // When junk is set, coef_valid stays high with random data. Any cycle with coef_ready high is flagged.
    task automatic run_search(input bit junk, output int rise_cyc, output int done_cyc, output bit ready_seen);
        int cyc;
        cyc        = 1;
        rise_cyc   = 0;
        done_cyc   = 0;
        ready_seen = 1'b0;
        while (cyc < LIMIT) begin
            if (err_valid && rise_cyc == 0) rise_cyc = cyc;
            if (coef_ready) ready_seen = 1'b1;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (junk) coef_data = 13'($urandom);
            @(negedge clk);
            cyc++;
        end
        coef_valid = 1'b0;
        if (done_cyc == 0) checkOutput("search_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_err(output bit ok);
        int guard;
        guard = 0;
        while (!err_valid && guard < LIMIT) begin
            @(negedge clk);
            guard++;
        end
        ok = err_valid;
        if (!ok) checkOutput("err_wait_timeout", 32'd0, 32'd1);
    endtask

    // Keep err_ready low for 10 cycles. Check that the pending position does not move
    // and that done does not appear. Then complete the handshake.
    task automatic stall_and_accept(input string tag, input logic [12:0] exp_pos);
        bit bad;
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (!err_valid || err_pos != exp_pos || done) bad = 1'b1;
            @(negedge clk);
        end
        checkOutput(tag, 32'(bad), 32'd0);
        err_ready = 1'b1;
        @(negedge clk);
        err_ready = 1'b0;
    endtask

    initial begin
        int rise_c;
        int done_c;
        bit rdy;
        bit ok;

        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        coef_valid = 1'b0;
        coef_data  = '0;
        deg        = '0;
        err_ready  = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_coef_ready", 32'(coef_ready), 32'd0);
        checkOutput("rst_err_valid",  32'(err_valid),  32'd0);
        checkOutput("rst_err_pos",    32'(err_pos),    32'd0);
        checkOutput("rst_done",       32'(done),       32'd0);
        checkOutput("rst_err_cnt",    32'(err_cnt),    32'd0);
        checkOutput("rst_fail",       32'(fail),       32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Lambda = 1, deg 0: no roots, done N+1 cycles after beat T
        $display("[TB] scenario 1: Lambda=1");
        err_q.delete();
        set_coefs(13'd1, 13'd0, 13'd0);
        applyStimulus(6'd0, 1'b0);
        run_search(1'b0, rise_c, done_c, rdy);
        checkOutput("s1_done_cycle", 32'(done_c), 32'(N + 1));
        checkOutput("s1_err_beats",  32'(err_q.size()), 32'd0);
        checkOutput("s1_err_cnt",    32'(err_cnt), 32'd0);
        checkOutput("s1_fail",       32'(fail), 32'd0);
        @(negedge clk);
        checkOutput("s1_done_pulse", 32'(done), 32'd0);
        checkOutput("s1_idle_ready", 32'(coef_ready), 32'd1);

        // Lambda = 1 + alpha^-5 x: single root at position 5.
        // Step 5 is evaluated in cycle 6, so err_valid is visible in cycle 7.
        $display("[TB] scenario 2: single root at 5");
        err_q.delete();
        set_coefs(13'd1, alpha_neg(5), 13'd0);
        applyStimulus(6'd1, 1'b0);
        run_search(1'b0, rise_c, done_c, rdy);
        checkOutput("s2_rise_cycle", 32'(rise_c), 32'd7);
        checkOutput("s2_err_beats",  32'(err_q.size()), 32'd1);
        checkOutput("s2_err_pos",    32'(err_q[0]), 32'd5);
        checkOutput("s2_err_cnt",    32'(err_cnt), 32'd1);
        checkOutput("s2_fail",       32'(fail), 32'd0);
        @(negedge clk);

        // Roots at 0 and N-1, i.e. (1+x)(1+alpha x), with err_ready stalled for 10 cycles each time
        $display("[TB] scenario 3: roots at 0 and N-1 with stalls");
        err_q.delete();
        err_ready = 1'b0;
        set_coefs(13'd1, 13'h0003, 13'h0002);
        applyStimulus(6'd2, 1'b0);
        wait_err(ok);
        checkOutput("s3_pos_first", 32'(err_pos), 32'd0);
        stall_and_accept("s3_stall_first", 13'd0);
        checkOutput("s3_valid_drop", 32'(err_valid), 32'd0);
        wait_err(ok);
        checkOutput("s3_pos_last", 32'(err_pos), 32'(N - 1));
        stall_and_accept("s3_stall_last", 13'(N - 1));
        checkOutput("s3_done_after_hs", 32'(done), 32'd1);
        checkOutput("s3_err_cnt",       32'(err_cnt), 32'd2);
        checkOutput("s3_fail",          32'(fail), 32'd0);
        checkOutput("s3_err_beats",     32'(err_q.size()), 32'd2);
        err_ready = 1'b1;
        @(negedge clk);

        // deg = 3 with only two roots (5 and 10): uncorrectable
        $display("[TB] scenario 4: deg 3, roots 5 and 10");
        err_q.delete();
        set_coefs(13'd1, alpha_neg(5) ^ alpha_neg(10), alpha_neg(15));
        applyStimulus(6'd3, 1'b0);
        run_search(1'b0, rise_c, done_c, rdy);
        checkOutput("s4_err_beats", 32'(err_q.size()), 32'd2);
        checkOutput("s4_pos0",      32'(err_q[0]), 32'd5);
        checkOutput("s4_pos1",      32'(err_q[1]), 32'd10);
        checkOutput("s4_err_cnt",   32'(err_cnt), 32'd2);
        checkOutput("s4_fail",      32'(fail), 32'd1);
        @(negedge clk);

        // Reset in the middle of a search, then reload
        $display("[TB] scenario 5: reset mid-search");
        err_q.delete();
        set_coefs(13'd1, alpha_neg(5), 13'd0);
        applyStimulus(6'd1, 1'b0);
        repeat (100) @(negedge clk);
        checkOutput("s5_cnt_before", 32'(err_cnt), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("s5_rst_err_valid",  32'(err_valid), 32'd0);
        checkOutput("s5_rst_err_cnt",    32'(err_cnt), 32'd0);
        checkOutput("s5_rst_done",       32'(done), 32'd0);
        checkOutput("s5_rst_coef_ready", 32'(coef_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("s5_idle_ready", 32'(coef_ready), 32'd1);
        err_q.delete();
        applyStimulus(6'd1, 1'b0);
        run_search(1'b0, rise_c, done_c, rdy);
        checkOutput("s5_err_beats", 32'(err_q.size()), 32'd1);
        checkOutput("s5_err_pos",   32'(err_q[0]), 32'd5);
        checkOutput("s5_err_cnt",   32'(err_cnt), 32'd1);
        @(negedge clk);

`ifdef CHIEN_EARLY_EXIT_EN
        // Roots 3 and 7 with deg 2: done the cycle after the second handshake
        $display("[TB] scenario 5b: early exit");
        err_q.delete();
        set_coefs(13'd1, alpha_neg(3) ^ alpha_neg(7), alpha_neg(10));
        applyStimulus(6'd2, 1'b0);
        wait_err(ok);
        @(negedge clk);
        wait_err(ok);
        checkOutput("s5b_pos", 32'(err_pos), 32'd7);
        @(negedge clk);
        checkOutput("s5b_done",    32'(done), 32'd1);
        checkOutput("s5b_err_cnt", 32'(err_cnt), 32'd2);
        checkOutput("s5b_fail",    32'(fail), 32'd0);
        @(negedge clk);
`endif

        // Scenario 2 again, with coef_valid held high and random data during the search
        $display("[TB] scenario 6: coef_valid held during search");
        err_q.delete();
        set_coefs(13'd1, alpha_neg(5), 13'd0);
        applyStimulus(6'd1, 1'b1);
        run_search(1'b1, rise_c, done_c, rdy);
        checkOutput("s6_ready_low", 32'(rdy), 32'd0);
        checkOutput("s6_rise_cycle", 32'(rise_c), 32'd7);
        checkOutput("s6_err_beats", 32'(err_q.size()), 32'd1);
        checkOutput("s6_err_pos",   32'(err_q[0]), 32'd5);
        checkOutput("s6_err_cnt",   32'(err_cnt), 32'd1);
        checkOutput("s6_fail",      32'(fail), 32'd0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
